// File: rtl/rac_scan_ctrl.sv
// Repair-address scan controller: stores faulty rows and sequences a registered comparator over them.
// Optional RAC_SHARED_SPARE_EN adds cfg_rlss so a block mismatch still counts as a hit.
module rac_scan_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 10,
  parameter int BW    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flt_valid,
  output logic                       flt_ready,
  input  logic [AW-1:0]              flt_addr,
  input  logic [BW-1:0]              flt_block,
  input  logic                       clr,
  output logic [AW-1:0]              rac_x_addr,
  output logic [BW-1:0]              rac_x_block,
  output logic [AW-1:0]              rac_p_addr,
  output logic [BW-1:0]              rac_p_block,
  output logic                       rac_rlss,
  input  logic                       rac_result,
`ifdef RAC_SHARED_SPARE_EN
  input  logic                       cfg_rlss,
`endif
  output logic                       res_valid,
  output logic                       res_hit,
  output logic [$clog2(DEPTH)-1:0]   res_idx,
  output logic                       res_alloc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int EW = AW + BW;
  localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, CHECK, ALLOC, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            hit_q, hit_d;
  logic            alloc_q, alloc_d;
  logic [IW-1:0]   res_idx_q, res_idx_d;
  logic [AW-1:0]   x_addr_q, x_addr_d;
  logic [BW-1:0]   x_blk_q, x_blk_d;
  logic [EW-1:0]   p_q, p_d;
  logic            mem_we;
  logic [EW-1:0]   mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    hit_d      = hit_q;
    alloc_d    = alloc_q;
    res_idx_d  = res_idx_q;
    x_addr_d   = x_addr_q;
    x_blk_d    = x_blk_q;
    p_d        = p_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (flt_valid && !clr) begin
          x_addr_d = flt_addr;
          x_blk_d  = flt_block;
          idx_d    = '0;
          p_d      = mem[0];
          state_d  = (count_q != '0) ? ISSUE : ALLOC;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (rac_result) begin
          hit_d     = 1'b1;
          alloc_d   = 1'b0;
          res_idx_d = idx_q;
          state_d   = DONE;
        end else if ({1'b0, idx_q} == count_q - 1'b1) begin
          state_d = ALLOC;
        end else begin
          // Prefetch the next entry so it is already on rac_p_* during ISSUE.
          idx_d   = idx_q + 1'b1;
          p_d     = mem[idx_q + 1'b1];
          state_d = ISSUE;
        end
      end
      ALLOC: begin
        hit_d = 1'b0;
        if (count_q < DEPTH_C) begin
          mem_we    = 1'b1;
          res_idx_d = count_q[IW-1:0];
          count_d   = count_q + 1'b1;
          alloc_d   = 1'b1;
        end else begin
          overflow_d = 1'b1;
          alloc_d    = 1'b0;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d    = IDLE;
      idx_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      hit_d      = 1'b0;
      alloc_d    = 1'b0;
      res_idx_d  = '0;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hit_q      <= 1'b0;
      alloc_q    <= 1'b0;
      res_idx_q  <= '0;
      x_addr_q   <= '0;
      x_blk_q    <= '0;
      p_q        <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hit_q      <= hit_d;
      alloc_q    <= alloc_d;
      res_idx_q  <= res_idx_d;
      x_addr_q   <= x_addr_d;
      x_blk_q    <= x_blk_d;
      p_q        <= p_d;
    end
  end

  // Entry storage is validity-tracked by count_q, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[IW-1:0]] <= {x_addr_q, x_blk_q};
  end

`ifdef RAC_SHARED_SPARE_EN
  logic rlss_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   rlss_q <= 1'b0;
    else if (state_q == IDLE && flt_valid && !clr) rlss_q <= cfg_rlss;
  end
  assign rac_rlss = rlss_q;
`else
  assign rac_rlss = 1'b0;
`endif

  assign flt_ready   = (state_q == IDLE) && !clr;
  assign res_valid   = (state_q == DONE) && !clr;
  assign res_hit     = hit_q;
  assign res_alloc   = alloc_q;
  assign res_idx     = res_idx_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign rac_x_addr  = x_addr_q;
  assign rac_x_block = x_blk_q;
  assign rac_p_addr  = p_q[EW-1:BW];
  assign rac_p_block = p_q[BW-1:0];

endmodule

// File: tb/tb_rac_scan_ctrl.sv
// Randomized bench for rac_scan_ctrl with a queue-based repair-table model and an external comparator.
module tb_rac_scan_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 10;
  localparam int BW    = 2;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flt_valid = 1'b0;
  logic          flt_ready;
  logic [AW-1:0] flt_addr = '0;
  logic [BW-1:0] flt_block = '0;
  logic          clr = 1'b0;
  logic [AW-1:0] rac_x_addr, rac_p_addr;
  logic [BW-1:0] rac_x_block, rac_p_block;
  logic          rac_rlss;
  logic          rac_result = 1'b0;
  logic          cfg_rlss = 1'b0;
  logic          res_valid, res_hit, res_alloc, overflow;
  logic [IW-1:0] res_idx;
  logic [IW:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of stored faults plus sticky/hold state.
  logic [AW-1:0] m_addr[$];
  logic [BW-1:0] m_blk[$];
  int            m_ovf = 0;
  int            m_idx = 0;

  rac_scan_ctrl #(.DEPTH(DEPTH), .AW(AW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .flt_valid(flt_valid), .flt_ready(flt_ready),
    .flt_addr(flt_addr), .flt_block(flt_block), .clr(clr),
    .rac_x_addr(rac_x_addr), .rac_x_block(rac_x_block),
    .rac_p_addr(rac_p_addr), .rac_p_block(rac_p_block),
    .rac_rlss(rac_rlss), .rac_result(rac_result),
`ifdef RAC_SHARED_SPARE_EN
    .cfg_rlss(cfg_rlss),
`endif
    .res_valid(res_valid), .res_hit(res_hit), .res_idx(res_idx),
    .res_alloc(res_alloc), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Registered comparator standing in for the RAC array.
  always @(posedge clk)
    rac_result <= (rac_x_addr == rac_p_addr) && ((rac_x_block == rac_p_block) || rac_rlss);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_fault(input logic [AW-1:0] a, input logic [BW-1:0] b, input bit rl);
    bit eff_rl;
    int j, k, exp_lat, lat, exp_hit, exp_alloc;
    bit got_ready;
`ifdef RAC_SHARED_SPARE_EN
    eff_rl = rl;
`else
    eff_rl = 1'b0;
`endif
    k = m_addr.size();
    j = -1;
    for (int i = 0; i < k; i++)
      if (j < 0 && m_addr[i] == a && (m_blk[i] == b || eff_rl)) j = i;
    if (j >= 0) begin
      exp_hit = 1; exp_alloc = 0; m_idx = j; exp_lat = 2*j + 3;
    end else begin
      exp_hit = 0; exp_lat = 2*k + 2;
      if (k < DEPTH) begin
        exp_alloc = 1; m_idx = k; m_addr.push_back(a); m_blk.push_back(b);
      end else begin
        exp_alloc = 0; m_ovf = 1;
      end
    end

    got_ready = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (flt_ready) begin got_ready = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got_ready) begin chk("ready_timeout", 0, 1); return; end

    cfg_rlss = rl; flt_addr = a; flt_block = b; flt_valid = 1'b1;
    @(posedge clk); #1;
    flt_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1 || 1) begin end
      if (res_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    if (lat == 0) begin chk("res_timeout", 0, 1); return; end

    chk("latency", lat, exp_lat);
    chk("res_hit", 32'(res_hit), exp_hit);
    chk("res_alloc", 32'(res_alloc), exp_alloc);
    chk("res_idx", 32'(res_idx), m_idx);
    chk("count", 32'(count), m_addr.size());
    chk("overflow", 32'(overflow), m_ovf);
    chk("rac_x", {rac_x_addr, rac_x_block}, {a, b});
    $display("fault a=%03h b=%0d rl=%0d -> hit=%0d alloc=%0d idx=%0d lat=%0d cnt=%0d ovf=%0d",
             a, b, rl, res_hit, res_alloc, res_idx, lat, count, overflow);
    @(posedge clk); #1;
    chk("pulse_once", 32'(res_valid), 0);
    chk("rx_hold", {rac_x_addr, rac_x_block}, {a, b});
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #1 chk("ready_in_clr", 32'(flt_ready), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    m_addr.delete(); m_blk.delete(); m_ovf = 0; m_idx = 0;
    chk("clr_count", 32'(count), 0);
    chk("clr_ovf", 32'(overflow), 0);
    $display("clr -> cnt=%0d ovf=%0d", count, overflow);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(flt_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {res_valid, res_hit, res_alloc, overflow}, 0);
    chk("rst_idx", 32'(res_idx), 0);
    chk("rst_rx", {rac_x_addr, rac_x_block}, 0);
    chk("rst_rp", {rac_p_addr, rac_p_block}, 0);
    chk("rst_rlss", 32'(rac_rlss), 0);

    do_fault(10'h155, 2'd1, 1'b0);
    do_fault(10'h0A0, 2'd2, 1'b0);
    do_fault(10'h0A0, 2'd2, 1'b0);
    do_fault(10'h155, 2'd3, 1'b1);

    do_clr();
    for (int i = 0; i < DEPTH; i++)
      do_fault(10'h300 + AW'(i), BW'($urandom_range(0, 3)), 1'b0);
    do_fault(10'h3FF, 2'd0, 1'b0);
    do_clr();

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) do_clr();
      else do_fault(10'h100 + AW'($urandom_range(0, 3)), BW'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a scan.
    do_clr();
    do_fault(10'h010, 2'd0, 1'b0);
    do_fault(10'h020, 2'd0, 1'b0);
    flt_addr = 10'h3FF; flt_block = 2'd0; cfg_rlss = 1'b0; flt_valid = 1'b1;
    @(posedge clk); #1 flt_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_rv", 32'(res_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    m_addr.delete(); m_blk.delete(); m_ovf = 0; m_idx = 0;
    chk("mid_rst_ready", 32'(flt_ready), 1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    chk("mid_rst_no_rv", 32'(seen), 0);
    $display("mid-scan reset -> cnt=%0d ready=%0d", count, flt_ready);
    do_fault(10'h2AA, 2'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
